fosfor_present_top: RTL and testbench

- Nibble-wide, register-mapped PRESENT-80 block-cipher accelerator sized for a tiny-tapeout slot (8 in, 8 out).
- The host writes 4-bit nibbles and commands over a 2-bit address strobe, and moves bytes between an 8-bit data register and an internal byte-addressed register file.
- The register file holds the 64-bit block, the 80-bit key, a test register and status.
- An iterative PRESENT core encrypts the block in place.

---
 rtl/fosfor_present_pkg.sv | 31 +++
 rtl/fosfor_present_if.sv | 20 ++
 rtl/fosfor_present_core.sv | 100 ++++++++++
 rtl/fosfor_present_top.sv | 101 ++++++++++
 tb/tb_fosfor_present_top.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fosfor_present_pkg.sv
// Shared constants for the nibble-bus PRESENT-80 accelerator: command codes,
// register map, S-box and round count.
package fosfor_present_pkg;

    localparam logic [3:0] CMD_LOADADDR = 4'b0001;
    localparam logic [3:0] CMD_READ     = 4'b0010;
    localparam logic [3:0] CMD_WRITE    = 4'b0100;
    localparam logic [3:0] CMD_START    = 4'b1000;

    localparam logic [7:0] ADDR_STATE_BASE = 8'h00;
    localparam logic [7:0] ADDR_TEST       = 8'h08;
    localparam logic [7:0] ADDR_STATUS     = 8'h09;
    localparam logic [7:0] ADDR_KEY_BASE   = 8'h10;

    localparam int unsigned KEY_BYTES  = 10;
    localparam int unsigned NUM_ROUNDS = 31;

    // Entry n of the PRESENT S-box sits at bits [4n+3:4n].
    localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic [1:0] {
        CORE_IDLE,
        CORE_ROUND,
        CORE_WHITEN
    } core_state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/fosfor_present_if.sv
// Host-side nibble bus: 2-bit strobe, 4-bit data/command in, registered byte out.
interface fosfor_present_if;

    logic [1:0] Address_b;
    logic [3:0] DataIn_b;
    logic [7:0] DataOut_b;

    modport master (
        output Address_b,
        output DataIn_b,
        input  DataOut_b
    );

    modport slave (
        input  Address_b,
        input  DataIn_b,
        output DataOut_b
    );

endinterface

// File: rtl/fosfor_present_core.sv
// Iterative PRESENT-80 engine: one round per cycle, then a whitening cycle.
// Owns the block register, working key and round counter.
module fosfor_present_core
    import fosfor_present_pkg::*;
(
    input  logic        Clk_k,
    input  logic        Reset_rn,
    input  logic        start,
    input  logic [79:0] key,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [7:0]  wr_data,
    output logic [63:0] state,
    output logic        busy,
    output logic        done
);

    core_state_e fsm_q, fsm_d;
    logic [63:0] state_q;
    logic [79:0] wkey_q;
    logic [4:0]  round_cnt_q;
    logic        done_q;
    logic [63:0] round_state;
    logic [79:0] next_key;

    function automatic logic [63:0] player(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++)
            y[(i * 16) % 63] = x[i];
        y[63] = x[63];
        return y;
    endfunction

    always_ff @(posedge Clk_k or negedge Reset_rn) begin
        if (!Reset_rn) fsm_q <= CORE_IDLE;
        else           fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            CORE_IDLE:   if (start) fsm_d = CORE_ROUND;
            CORE_ROUND:  if (round_cnt_q == 5'(NUM_ROUNDS)) fsm_d = CORE_WHITEN;
            CORE_WHITEN: fsm_d = CORE_IDLE;
            default:     fsm_d = CORE_IDLE;
        endcase
    end

    always_comb begin
        logic [63:0] mixed;
        logic [63:0] subst;
        mixed = state_q ^ wkey_q[79:16];
        subst = '0;
        for (int n = 0; n < 16; n++)
            subst[n * 4 +: 4] = sbox4(mixed[n * 4 +: 4]);
        round_state = player(subst);

        next_key = {wkey_q[18:0], wkey_q[79:19]};
        next_key[79:76] = sbox4(next_key[79:76]);
        next_key[19:15] = next_key[19:15] ^ round_cnt_q;
    end

    // Round counter wraps 31 -> 0 on the last round; the whitening step ignores it.
    always_ff @(posedge Clk_k or negedge Reset_rn) begin
        if (!Reset_rn) begin
            state_q     <= '0;
            wkey_q      <= '0;
            round_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            case (fsm_q)
                CORE_IDLE: begin
                    if (start) begin
                        wkey_q      <= key;
                        round_cnt_q <= 5'd1;
                        done_q      <= 1'b0;
                    end else if (wr_en) begin
                        state_q[{wr_idx, 3'b000} +: 8] <= wr_data;
                    end
                end
                CORE_ROUND: begin
                    state_q     <= round_state;
                    wkey_q      <= next_key;
                    round_cnt_q <= round_cnt_q + 5'd1;
                end
                CORE_WHITEN: begin
                    state_q <= state_q ^ wkey_q[79:16];
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;
    assign busy  = (fsm_q != CORE_IDLE);
    assign done  = done_q;

endmodule

// File: rtl/fosfor_present_top.sv
// PRESENT-80 accelerator top: nibble bus decode and byte register file around
// the cipher core. Define FOSFOR_TEST_REG_EN to keep the scratch register at 0x08.
module fosfor_present_top
    import fosfor_present_pkg::*;
(
    input  logic             Clk_k,
    input  logic             Reset_rn,
    fosfor_present_if.slave  bus
);

    logic [7:0]  data_reg;
    logic [7:0]  addr_reg;
    logic [79:0] key_q;
    logic [7:0]  data_out_q;
    logic [7:0]  rd_byte;
    logic [63:0] core_state;
    logic        busy;
    logic        done;
    logic        cmd_valid;
    logic        cmd_write;
    logic        is_state;
    logic        is_key;
    logic [3:0]  key_idx;

    assign cmd_valid = (bus.Address_b == 2'd1);
    assign cmd_write = cmd_valid && (bus.DataIn_b == CMD_WRITE);
    assign is_state  = (addr_reg[7:3] == ADDR_STATE_BASE[7:3]);
    assign key_idx   = addr_reg[3:0];
    assign is_key    = (addr_reg[7:4] == ADDR_KEY_BASE[7:4]) && (key_idx < 4'(KEY_BYTES));

`ifdef FOSFOR_TEST_REG_EN
    logic [7:0] test_q;

    always_ff @(posedge Clk_k or negedge Reset_rn) begin
        if (!Reset_rn)                             test_q <= '0;
        else if (cmd_write && addr_reg == ADDR_TEST) test_q <= data_reg;
    end
`endif

    always_comb begin
        rd_byte = 8'h00;
        if (is_state)
            rd_byte = core_state[{addr_reg[2:0], 3'b000} +: 8];
        else if (is_key)
            rd_byte = 8'(key_q >> {key_idx, 3'b000});
        else if (addr_reg == ADDR_STATUS)
            rd_byte = {6'b000000, done, busy};
`ifdef FOSFOR_TEST_REG_EN
        else if (addr_reg == ADDR_TEST)
            rd_byte = test_q;
`endif
    end

    // Strobes are level-sensitive: every edge with a non-idle strobe acts again.
    always_ff @(posedge Clk_k or negedge Reset_rn) begin
        if (!Reset_rn) begin
            data_reg   <= '0;
            addr_reg   <= '0;
            key_q      <= '0;
            data_out_q <= '0;
        end else begin
            case (bus.Address_b)
                2'd2: begin
                    data_out_q    <= data_reg;
                    data_reg[3:0] <= bus.DataIn_b;
                end
                2'd3: data_reg[7:4] <= bus.DataIn_b;
                2'd1: begin
                    case (bus.DataIn_b)
                        CMD_LOADADDR: addr_reg <= data_reg;
                        CMD_READ:     data_reg <= rd_byte;
                        CMD_WRITE: begin
                            if (is_key && !busy) begin
                                for (int i = 0; i < KEY_BYTES; i++)
                                    if (key_idx == 4'(i)) key_q[i * 8 +: 8] <= data_reg;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    fosfor_present_core u_core (
        .Clk_k    (Clk_k),
        .Reset_rn (Reset_rn),
        .start    (cmd_valid && (bus.DataIn_b == CMD_START) && !busy),
        .key      (key_q),
        .wr_en    (cmd_write && is_state && !busy),
        .wr_idx   (addr_reg[2:0]),
        .wr_data  (data_reg),
        .state    (core_state),
        .busy     (busy),
        .done     (done)
    );

    assign bus.DataOut_b = data_out_q;

endmodule

// File: tb/tb_fosfor_present_top.sv
// Self-checking bench for fosfor_present_top: known-answer table, register-file
// model with random accesses, random plaintext/key against a PRESENT model.
module tb_fosfor_present_top;
    import fosfor_present_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fosfor_present_if bus ();

    fosfor_present_top dut (
        .Clk_k    (clk),
        .Reset_rn (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [63:0] pt;
        logic [79:0] key;
        logic [63:0] ct;
    } vec_t;

    int unsigned sb_tab [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    function automatic logic [63:0] ref_present(input logic [63:0] pt, input logic [79:0] key);
        logic [79:0] k;
        logic [63:0] s;
        logic [63:0] t;
        k = key;
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++)
                s[n * 4 +: 4] = 4'(sb_tab[s[n * 4 +: 4]]);
            t = '0;
            for (int b = 0; b < 64; b++)
                t[(b % 4) * 16 + (b / 4)] = s[b];
            s = t;
            k = {k[18:0], k[79:19]};
            k[79:76] = 4'(sb_tab[k[79:76]]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive after a falling edge, exactly one rising edge sees it.
    task automatic op(input logic [1:0] a, input logic [3:0] n);
        bus.Address_b = a;
        bus.DataIn_b  = n;
        @(negedge clk);
        bus.Address_b = 2'd0;
        bus.DataIn_b  = 4'd0;
    endtask

    task automatic set_data(input logic [7:0] v);
        op(2'd2, v[3:0]);
        op(2'd3, v[7:4]);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] v);
        set_data(a);
        op(2'd1, CMD_LOADADDR);
        set_data(v);
        op(2'd1, CMD_WRITE);
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] v);
        set_data(a);
        op(2'd1, CMD_LOADADDR);
        op(2'd1, CMD_READ);
        op(2'd2, 4'h0);
        v = bus.DataOut_b;
    endtask

    task automatic load_vec(input logic [63:0] pt, input logic [79:0] key);
        for (int i = 0; i < 8; i++)  wr_reg(8'(i), pt[i * 8 +: 8]);
        for (int i = 0; i < 10; i++) wr_reg(8'h10 + 8'(i), key[i * 8 +: 8]);
    endtask

    task automatic read_ct(output logic [63:0] ct);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            rd_reg(8'(i), b);
            ct[i * 8 +: 8] = b;
        end
    endtask

    task automatic read_key(output logic [79:0] key);
        logic [7:0] b;
        for (int i = 0; i < 10; i++) begin
            rd_reg(8'h10 + 8'(i), b);
            key[i * 8 +: 8] = b;
        end
    endtask

    // Status is probed on the 32nd edge after START (still busy) and the 34th (done).
    task automatic run_enc(input logic [63:0] pt, input logic [79:0] key, output logic [63:0] ct);
        logic [7:0] s;
        load_vec(pt, key);
        set_data(ADDR_STATUS);
        op(2'd1, CMD_LOADADDR);
        op(2'd1, CMD_START);
        repeat (31) op(2'd0, 4'h0);
        op(2'd1, CMD_READ);
        op(2'd2, 4'h0);
        check("lat_busy", 80'(bus.DataOut_b), 80'h01);
        op(2'd1, CMD_READ);
        op(2'd2, 4'h0);
        check("lat_done", 80'(bus.DataOut_b), 80'h02);
        read_ct(ct);
        rd_reg(ADDR_STATUS, s);
        check("done_sticky", 80'(s), 80'h02);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [4];
        logic [7:0]  mdl [256];
        logic [7:0]  rb;
        logic [7:0]  exp_test;
        logic [63:0] ct;
        logic [79:0] kr;
        logic [63:0] pt;
        logic [79:0] key;

        vecs[0] = '{64'h0000_0000_0000_0000, 80'h0000_0000_0000_0000_0000, 64'h5579_C138_7B22_8445};
        vecs[1] = '{64'h0000_0000_0000_0000, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 64'hE72C_46C0_F594_5049};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h0000_0000_0000_0000_0000, 64'hA112_FFC7_2F68_417B};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 64'h3333_DCD3_2132_10D2};

        bus.Address_b = 2'd0;
        bus.DataIn_b  = 4'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dataout", 80'(bus.DataOut_b), 80'h00);
        rst_n = 1'b1;
        @(negedge clk);
        rd_reg(ADDR_STATUS, rb);
        check("reset_status", 80'(rb), 80'h00);

        // Random register-file traffic against an address-level model.
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a;
            logic [7:0] v;
            logic       writable;
            case ($urandom_range(0, 4))
                0, 1:    a = 8'($urandom_range(0, 7));
                2:       a = 8'h10 + 8'($urandom_range(0, 9));
                3:       a = 8'($urandom_range(8, 9));
                default: a = 8'($urandom_range(0, 255));
            endcase
            v = 8'($urandom);
            writable = (a < 8'h08) || (a >= 8'h10 && a <= 8'h19);
`ifdef FOSFOR_TEST_REG_EN
            writable = writable || (a == 8'h08);
`endif
            if ($urandom_range(0, 1) == 1) begin
                wr_reg(a, v);
                if (writable) mdl[a] = v;
            end else begin
                rd_reg(a, rb);
                check($sformatf("regfile_rd_%02h", a), 80'(rb), 80'(mdl[a]));
            end
        end

        // Scratch register round trip.
        wr_reg(ADDR_TEST, 8'hA5);
        rd_reg(ADDR_TEST, rb);
`ifdef FOSFOR_TEST_REG_EN
        exp_test = 8'hA5;
`else
        exp_test = 8'h00;
`endif
        check("test_reg", 80'(rb), 80'(exp_test));

        // Unmapped addresses and non one-hot commands.
        wr_reg(8'h30, 8'h5A);
        rd_reg(8'h30, rb);
        check("unmapped_30", 80'(rb), 80'h00);
        wr_reg(8'h1A, 8'h5A);
        rd_reg(8'h1A, rb);
        check("unmapped_1a", 80'(rb), 80'h00);
        wr_reg(ADDR_STATUS, 8'hFF);
        rd_reg(ADDR_STATUS, rb);
        check("status_ro", 80'(rb), 80'h00);
        wr_reg(8'h00, 8'h3C);
        set_data(8'h77);
        op(2'd1, 4'b0011);
        op(2'd1, 4'b1100);
        op(2'd1, 4'b1111);
        op(2'd1, 4'b0000);
        op(2'd2, 4'h0);
        check("unk_cmd_data", 80'(bus.DataOut_b), 80'h77);
        rd_reg(ADDR_STATUS, rb);
        check("unk_cmd_status", 80'(rb), 80'h00);
        rd_reg(8'h00, rb);
        check("unk_cmd_state", 80'(rb), 80'h3C);

        // Known-answer table.
        for (int i = 0; i < 4; i++) begin
            run_enc(vecs[i].pt, vecs[i].key, ct);
            check($sformatf("kat%0d_ct", i), 80'(ct), 80'(vecs[i].ct));
            read_key(kr);
            check($sformatf("kat%0d_key", i), kr, vecs[i].key);
        end

        // Random plaintext/key against the model.
        for (int i = 0; i < 10; i++) begin
            pt  = {$urandom, $urandom};
            key = {16'($urandom), $urandom, $urandom};
            run_enc(pt, key, ct);
            check($sformatf("rand%0d_ct", i), 80'(ct), 80'(ref_present(pt, key)));
        end

        // Writes and a second START during a run must not disturb it.
        pt  = 64'h0123_4567_89AB_CDEF;
        key = 80'h0011_2233_4455_6677_8899;
        load_vec(pt, key);
        set_data(8'h00);
        op(2'd1, CMD_LOADADDR);
        set_data(8'h12);
        op(2'd1, CMD_START);
        repeat (4) op(2'd0, 4'h0);
        op(2'd1, CMD_WRITE);
        op(2'd1, CMD_START);
        rd_reg(ADDR_STATUS, rb);
        check("busy_status", 80'(rb), 80'h01);
        repeat (30) op(2'd0, 4'h0);
        rd_reg(ADDR_STATUS, rb);
        check("busy_done", 80'(rb), 80'h02);
        read_ct(ct);
        check("busy_ct", 80'(ct), 80'(ref_present(pt, key)));

        // Asynchronous reset in the middle of a run.
        set_data(ADDR_STATUS);
        op(2'd1, CMD_LOADADDR);
        op(2'd1, CMD_START);
        repeat (10) op(2'd0, 4'h0);
        op(2'd2, 4'h0);
        #2 rst_n = 1'b0;
        #1 check("midrun_rst_dataout", 80'(bus.DataOut_b), 80'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_reg(ADDR_STATUS, rb);
        check("midrun_rst_status", 80'(rb), 80'h00);
        rd_reg(8'h10, rb);
        check("midrun_rst_key10", 80'(rb), 80'h00);
        rd_reg(8'h19, rb);
        check("midrun_rst_key19", 80'(rb), 80'h00);
        rd_reg(8'h00, rb);
        check("midrun_rst_state0", 80'(rb), 80'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
